// File: rtl/sobel_edge_post_pkg.sv
// Shared constants and types for the Sobel post-processing stage.
package sobel_edge_post_pkg;

`ifdef VGA_640x480p60
    localparam int unsigned SIZE_X_DEF = 640;
    localparam int unsigned SIZE_Y_DEF = 480;
`else
    localparam int unsigned SIZE_X_DEF = 800;
    localparam int unsigned SIZE_Y_DEF = 600;
`endif

    // Window centre sits one line plus one pixel in, then three pipeline clocks.
    localparam int unsigned LATENCY_DEF = SIZE_X_DEF + 4;
    localparam int unsigned BORDER_DEF  = 1;

    localparam int unsigned MAG_W = 10;
    localparam int unsigned POS_W = 12;
    localparam int unsigned CNT_W = 20;

    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_BIN  = 1'b1;

    localparam logic [MAG_W-1:0] MAG_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        StIdle,
        StSkip,
        StActive,
        StDone
    } state_e;

endpackage

// File: rtl/sobel_pos_counter.sv
// Skip counter and x/y position tracking for the Sobel post stage.
module sobel_pos_counter
    import sobel_edge_post_pkg::*;
#(
    parameter int unsigned SIZE_X  = SIZE_X_DEF,
    parameter int unsigned SIZE_Y  = SIZE_Y_DEF,
    parameter int unsigned LATENCY = LATENCY_DEF,
    parameter int unsigned BORDER  = BORDER_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_skip_en,
    input  logic             i_pix_en,
    output logic             o_skip_done,
    output logic             o_last_pix,
    output logic             o_border,
    output logic [POS_W-1:0] o_x,
    output logic [POS_W-1:0] o_y
);

    localparam int unsigned SKIP_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(LATENCY - 1);
    localparam logic [POS_W-1:0]  X_LAST    = POS_W'(SIZE_X - 1);
    localparam logic [POS_W-1:0]  Y_LAST    = POS_W'(SIZE_Y - 1);
    localparam logic [POS_W-1:0]  X_LO      = POS_W'(BORDER);
    localparam logic [POS_W-1:0]  Y_LO      = POS_W'(BORDER);
    localparam logic [POS_W-1:0]  X_HI      = POS_W'(SIZE_X - BORDER);
    localparam logic [POS_W-1:0]  Y_HI      = POS_W'(SIZE_Y - BORDER);

    logic [SKIP_W-1:0] r_skip;
    logic [POS_W-1:0]  r_x;
    logic [POS_W-1:0]  r_y;

    // Count discarded fill samples, then raster-scan the accepted pixels.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skip <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else if (i_clear) begin
            r_skip <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            if (i_skip_en && (r_skip != SKIP_LAST)) begin
                r_skip <= r_skip + 1'b1;
            end
            if (i_pix_en) begin
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    // Flags describe the sample currently presented, not the next one.
    assign o_skip_done = (r_skip == SKIP_LAST);
    assign o_last_pix  = (r_x == X_LAST) && (r_y == Y_LAST);
    assign o_border    = (r_x < X_LO) || (r_x >= X_HI) || (r_y < Y_LO) || (r_y >= Y_HI);
    assign o_x         = r_x;
    assign o_y         = r_y;

endmodule

// File: rtl/sobel_edge_post.sv
// Sobel post stage: drops fill samples, blanks borders, thresholds and counts edges.
module sobel_edge_post
    import sobel_edge_post_pkg::*;
#(
    parameter int unsigned SIZE_X  = SIZE_X_DEF,
    parameter int unsigned SIZE_Y  = SIZE_Y_DEF,
    parameter int unsigned LATENCY = LATENCY_DEF,
    parameter int unsigned BORDER  = BORDER_DEF
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iFVAL,
    input  logic             iDVAL,
    input  logic [MAG_W-1:0] iMAG,
    input  logic [MAG_W-1:0] iTHRESH,
    input  logic             iMODE,
    output logic [MAG_W-1:0] oDATA,
    output logic             oDVAL,
    output logic             oEDGE,
    output logic [POS_W-1:0] oX,
    output logic [POS_W-1:0] oY,
    output logic [CNT_W-1:0] oEDGE_CNT,
    output logic             oCNT_VLD,
    output logic             oFRAME_ERR
);

    state_e           r_state;
    logic             r_fval;
    logic [MAG_W-1:0] r_thresh;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cnt_out;
    logic             r_cnt_vld;
    logic             r_err;
    logic [MAG_W-1:0] r_data;
    logic             r_dval;
    logic             r_edge;
    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;

    logic             w_start;
    logic             w_skip_en;
    logic             w_pix_en;
    logic             w_skip_done;
    logic             w_last_pix;
    logic             w_border;
    logic [POS_W-1:0] w_x;
    logic [POS_W-1:0] w_y;
    logic             w_edge;
    logic [MAG_W-1:0] w_data;

    // A frame may only start from IDLE or in the DONE cycle.
    assign w_start   = iFVAL && !r_fval && ((r_state == StIdle) || (r_state == StDone));
    assign w_skip_en = (r_state == StSkip) && iFVAL && iDVAL;
    assign w_pix_en  = (r_state == StActive) && iFVAL && iDVAL;

    sobel_pos_counter #(
        .SIZE_X  (SIZE_X),
        .SIZE_Y  (SIZE_Y),
        .LATENCY (LATENCY),
        .BORDER  (BORDER)
    ) u_pos (
        .i_clk       (iCLK),
        .i_rst_n     (iRST_N),
        .i_clear     (w_start),
        .i_skip_en   (w_skip_en),
        .i_pix_en    (w_pix_en),
        .o_skip_done (w_skip_done),
        .o_last_pix  (w_last_pix),
        .o_border    (w_border),
        .o_x         (w_x),
        .o_y         (w_y)
    );

    assign w_edge = !w_border && (iMAG >= r_thresh);
    assign w_data = w_border             ? '0 :
                    (r_mode == MODE_BIN) ? (w_edge ? MAG_MAX : '0) :
                                           iMAG;

    // Registered copy of iFVAL for rising-edge detection.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_fval <= 1'b0;
        end else begin
            r_fval <= iFVAL;
        end
    end

    // Frame FSM with threshold/mode capture, edge count and error flag.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= StIdle;
            r_thresh  <= '0;
            r_mode    <= MODE_PASS;
            r_cnt     <= '0;
            r_cnt_out <= '0;
            r_cnt_vld <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_cnt_vld <= 1'b0;
            case (r_state)
                StIdle: ;
                StSkip: begin
                    if (!iFVAL) begin
                        r_state <= StDone;
                        r_err   <= 1'b1;
                    end else if (w_skip_en && w_skip_done) begin
                        r_state <= StActive;
                    end
                end
                StActive: begin
                    if (!iFVAL) begin
                        r_state <= StDone;
                        r_err   <= 1'b1;
                    end else if (w_pix_en) begin
                        if (w_edge && (r_cnt != CNT_MAX)) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (w_last_pix) begin
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_cnt_out <= r_cnt;
                    r_cnt_vld <= 1'b1;
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
            // Overrides the DONE->IDLE step so back-to-back frames go straight to SKIP.
            if (w_start) begin
                r_state  <= StSkip;
                r_thresh <= iTHRESH;
                r_mode   <= iMODE;
                r_cnt    <= '0;
                r_err    <= 1'b0;
            end
        end
    end

    // One-stage pixel register; data and position hold while no pixel is accepted.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_dval <= 1'b0;
            r_data <= '0;
            r_edge <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            r_dval <= w_pix_en;
            if (w_pix_en) begin
                r_data <= w_data;
                r_edge <= w_edge;
                r_x    <= w_x;
                r_y    <= w_y;
            end
        end
    end

    assign oDATA      = r_data;
    assign oDVAL      = r_dval;
    assign oEDGE      = r_edge;
    assign oX         = r_x;
    assign oY         = r_y;
    assign oEDGE_CNT  = r_cnt_out;
    assign oCNT_VLD   = r_cnt_vld;
    assign oFRAME_ERR = r_err;

endmodule
